// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the hex-to-segment decode table (active-low, {g,f,e,d,c,b,a}).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bch_7seg.sv
// Combinational 4-bit to active-low 7-segment decoder.
module bch_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/mux_7seg_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered
// digit data, per-slot anti-ghosting blanking and optional leading-zero blanking.
module mux_7seg_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lzb_en,
  input  logic                  load,
  output seg_t                  seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_digits
    $error("mux_7seg_display: N_DIGITS must be in 1..16");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("mux_7seg_display: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("mux_7seg_display: BLANK_CYCLES must be in 0..REFRESH_DIV-1");
  end

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [4*N_DIGITS-1:0] shadow_value, disp_value;
  logic [N_DIGITS-1:0]   shadow_dp, shadow_blank, disp_dp, disp_blank;
  logic                  slot_end, wrap_evt;

  assign slot_end = (div_cnt == DIV_LAST);
  assign wrap_evt = slot_end && (digit_idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // The displayed frame only changes on the scan wrap; a load landing on that
  // same edge bypasses the shadow so it is not delayed by a whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
    end else begin
      if (load) begin
        shadow_value <= value_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
      if (wrap_evt) begin
        disp_value <= load ? value_in : shadow_value;
        disp_dp    <= load ? dp_in    : shadow_dp;
        disp_blank <= load ? blank_in : shadow_blank;
      end
    end
  end

  logic [IDX_W-1:0]    msd_idx;
  logic [N_DIGITS-1:0] visible;

  // Highest nonzero nibble wins; digit 0 is never above it, so it always survives LZB.
  always_comb begin
    msd_idx = '0;
    visible = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (disp_value[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      visible[i] = !disp_blank[i] && !(lzb_en && (IDX_W'(i) > msd_idx));
    end
  end

  logic [3:0]          sel_nibble;
  logic                sel_dp, sel_visible, lit;
  logic [N_DIGITS-1:0] an_next;
  seg_t                dec_seg;

  always_comb begin
    sel_nibble  = 4'h0;
    sel_dp      = 1'b0;
    sel_visible = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_nibble  = disp_value[4*i +: 4];
        sel_dp      = disp_dp[i];
        sel_visible = visible[i];
      end
    end
  end

  assign lit = sel_visible && (div_cnt >= BLANK_END);

  always_comb begin
    an_next = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && (digit_idx == IDX_W'(i))) an_next[i] = 1'b0;
    end
  end

  bch_7seg u_decoder (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_n      <= lit ? dec_seg : SEG_OFF;
      dp_n       <= lit ? ~sel_dp : 1'b1;
      an_n       <= an_next;
      frame_tick <= wrap_evt;
    end
  end

endmodule
